// File: rtl/vga_color_sched_if.sv
// Button, blanking-strobe and committed-colour signals between the board/timing
// side and the colour scheduler.
interface vga_color_sched_if;
    logic       but_R;
    logic       but_G;
    logic       but_B;
    logic       vblank_start;
    logic [3:0] out_R;
    logic [3:0] out_G;
    logic [3:0] out_B;
    logic       upd;

    // Board/timing side: drives raw buttons and the strobe, observes colours.
    modport master (
        output but_R, but_G, but_B, vblank_start,
        input  out_R, out_G, out_B, upd
    );

    // Scheduler side.
    modport slave (
        input  but_R, but_G, but_B, vblank_start,
        output out_R, out_G, out_B, upd
    );
endinterface

// File: rtl/vga_color_sched.sv
// Frame-synchronous colour controller: synchronises and debounces three colour
// buttons, counts pending steps per channel, and applies them to the displayed
// colour only on the vertical-blanking strobe so colours never change mid-frame.
module vga_color_sched #(
    parameter int         DEB_CYCLES = 250000,
    parameter int         CNT_W      = 18,
    parameter logic [3:0] INIT_R     = 4'h0,
    parameter logic [3:0] INIT_G     = 4'h0,
    parameter logic [3:0] INIT_B     = 4'h0
) (
    input  logic               clk,
    input  logic               rst,
    vga_color_sched_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, PRESS, HELD, REL} deb_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    // Channel index order: 0 = red, 1 = green, 2 = blue.
    logic [2:0]       raw;
    logic [2:0]       sync1;
    logic [2:0]       syn;
    logic [2:0]       press;
    deb_state_t       state     [3];
    deb_state_t       state_nxt [3];
    logic [CNT_W-1:0] cnt       [3];
    logic [CNT_W-1:0] cnt_nxt   [3];
    logic [3:0]       pend      [3];
    logic [3:0]       out_q     [3];
    logic             upd_q;

    assign raw = {bus.but_B, bus.but_G, bus.but_R};

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample the pre-edge value,
        // so sync1 -> syn really is a two-stage pipeline.
        if (rst) begin
            sync1 <= '0;
            syn   <= '0;
        end else begin
            sync1 <= raw;
            syn   <= sync1;
        end
    end

    // Debounce state and counter registers, one set per channel.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end else begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

    // Debounce next-state logic; a press pulse fires once when a press is accepted.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            // NOTE: every output gets a default before the case so no path leaves
            // a value unassigned, which would otherwise infer a latch.
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            press[i]     = 1'b0;
            case (state[i])
                IDLE: begin
                    if (syn[i]) begin
                        state_nxt[i] = PRESS;
                        cnt_nxt[i]   = '0;
                    end
                end
                PRESS: begin
                    if (!syn[i]) begin
                        state_nxt[i] = IDLE;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = HELD;
                        press[i]     = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                HELD: begin
                    if (!syn[i]) begin
                        state_nxt[i] = REL;
                        cnt_nxt[i]   = '0;
                    end
                end
                REL: begin
                    if (syn[i]) begin
                        state_nxt[i] = HELD;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = IDLE;
                    end else begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                default: state_nxt[i] = IDLE;
            endcase
        end
    end

    // Pending-step accumulation and commit on the blanking strobe; a press landing
    // on the strobe cycle is held over to the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the small pend/out arrays are real state and are reset explicitly;
            // nothing here relies on power-up values.
            out_q[0] <= INIT_R;
            out_q[1] <= INIT_G;
            out_q[2] <= INIT_B;
            for (int i = 0; i < 3; i++) pend[i] <= '0;
            upd_q <= 1'b0;
        end else if (bus.vblank_start) begin
            for (int i = 0; i < 3; i++) begin
                out_q[i] <= out_q[i] + pend[i];
                pend[i]  <= 4'(press[i]);
            end
            upd_q <= (pend[0] != '0) || (pend[1] != '0) || (pend[2] != '0);
        end else begin
            for (int i = 0; i < 3; i++) pend[i] <= pend[i] + 4'(press[i]);
            upd_q <= 1'b0;
        end
    end

    assign bus.out_R = out_q[0];
    assign bus.out_G = out_q[1];
    assign bus.out_B = out_q[2];
    assign bus.upd   = upd_q;

endmodule
